// File: rtl/lsu_dcache_adapter_if.sv
// Bundles between the load/store adapter and its neighbours:
// lsu_req_if faces execute/writeback, dcache_if faces the data cache.

interface lsu_req_if #(
  parameter int DATA_LENGTH = 32,
  parameter int ADDR_LENGTH = 32
);
  logic                   req_valid;
  logic                   req_ready;
  logic                   req_rw;
  logic [1:0]             req_size;
  logic                   req_unsigned;
  logic [ADDR_LENGTH-1:0] req_addr;
  logic [DATA_LENGTH-1:0] req_wdata;
  logic [4:0]             req_rd;
  logic                   resp_valid;
  logic                   resp_ready;
  logic [DATA_LENGTH-1:0] resp_rdata;
  logic [4:0]             resp_rd;
  logic                   resp_misaligned;

  modport master (
    output req_valid, req_rw, req_size, req_unsigned, req_addr, req_wdata, req_rd,
    output resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_rd, resp_misaligned
  );

  modport slave (
    input  req_valid, req_rw, req_size, req_unsigned, req_addr, req_wdata, req_rd,
    input  resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_rd, resp_misaligned
  );
endinterface

interface dcache_if #(
  parameter int DATA_LENGTH = 32,
  parameter int ADDR_LENGTH = 32
);
  logic [ADDR_LENGTH-1:0] dc_addr;
  logic [DATA_LENGTH-1:0] dc_wdata;
  logic [DATA_LENGTH-1:0] dc_wmask;
  logic                   dc_rw;
  logic                   dc_valid;
  logic                   dc_ready;
  logic [DATA_LENGTH-1:0] dc_rdata;
  logic                   dc_rvalid;

  modport master (
    output dc_addr, dc_wdata, dc_wmask, dc_rw, dc_valid,
    input  dc_ready, dc_rdata, dc_rvalid
  );

  modport slave (
    input  dc_addr, dc_wdata, dc_wmask, dc_rw, dc_valid,
    output dc_ready, dc_rdata, dc_rvalid
  );
endinterface

// File: rtl/lsu_dcache_adapter.sv
// Load/store adapter in front of the data cache: alignment check, store lane
// formation, cache handshake and load extraction, one op in flight at a time.
//
// state   | meaning
// IDLE    | ready for a new op from execute
// ISSUE   | request presented to the cache, waiting for dc_ready
// WAIT    | load accepted by the cache, waiting for dc_rvalid
// RESP    | result presented to writeback, waiting for resp_ready

module lsu_dcache_adapter #(
  parameter int DATA_LENGTH = 32,
  parameter int ADDR_LENGTH = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  lsu_req_if.slave   lsu,
  dcache_if.master   dc
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic                   rw_q;
  logic [1:0]             size_q;
  logic                   unsigned_q;
  logic [1:0]             off_q;
  logic [4:0]             rd_q;
  logic [ADDR_LENGTH-1:0] dc_addr_q;
  logic [DATA_LENGTH-1:0] dc_wdata_q, dc_wdata_d;
  logic [DATA_LENGTH-1:0] dc_wmask_q, dc_wmask_d;
  logic [DATA_LENGTH-1:0] resp_rdata_q;
  logic                   resp_mis_q;

  logic                   accept;
  logic                   capture;
  logic                   misaligned;
  logic [4:0]             lane_sh;
  logic [DATA_LENGTH-1:0] rdata_sh;
  logic [DATA_LENGTH-1:0] load_ext;

  always_comb begin
    misaligned = 1'b0;
    unique case (lsu.req_size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = lsu.req_addr[0];
      2'b10:   misaligned = |lsu.req_addr[1:0];
      default: misaligned = 1'b1;
    endcase
  end

  assign lane_sh = {lsu.req_addr[1:0], 3'b000};

  // Loads leave mask and data at zero so the cache never sees stale lanes.
  always_comb begin
    dc_wmask_d = '0;
    dc_wdata_d = '0;
    if (lsu.req_rw) begin
      unique case (lsu.req_size)
        2'b00: begin
          dc_wmask_d = {{(DATA_LENGTH-8){1'b0}}, 8'hFF} << lane_sh;
          dc_wdata_d = {{(DATA_LENGTH-8){1'b0}}, lsu.req_wdata[7:0]} << lane_sh;
        end
        2'b01: begin
          dc_wmask_d = {{(DATA_LENGTH-16){1'b0}}, 16'hFFFF} << lane_sh;
          dc_wdata_d = {{(DATA_LENGTH-16){1'b0}}, lsu.req_wdata[15:0]} << lane_sh;
        end
        default: begin
          dc_wmask_d = '1;
          dc_wdata_d = lsu.req_wdata;
        end
      endcase
    end
  end

  assign rdata_sh = dc.dc_rdata >> {off_q, 3'b000};

  always_comb begin
    load_ext = rdata_sh;
    unique case (size_q)
      2'b00:   load_ext = unsigned_q ? {{(DATA_LENGTH-8){1'b0}}, rdata_sh[7:0]}
                                     : {{(DATA_LENGTH-8){rdata_sh[7]}}, rdata_sh[7:0]};
      2'b01:   load_ext = unsigned_q ? {{(DATA_LENGTH-16){1'b0}}, rdata_sh[15:0]}
                                     : {{(DATA_LENGTH-16){rdata_sh[15]}}, rdata_sh[15:0]};
      default: load_ext = rdata_sh;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (lsu.req_valid) begin
          accept  = 1'b1;
          state_d = misaligned ? S_RESP : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (dc.dc_ready) begin
          if (rw_q) begin
            state_d = S_RESP;
          end else if (dc.dc_rvalid) begin
            capture = 1'b1;
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (dc.dc_rvalid) begin
          capture = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (lsu.resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rw_q         <= 1'b0;
      size_q       <= 2'b00;
      unsigned_q   <= 1'b0;
      off_q        <= 2'b00;
      rd_q         <= 5'd0;
      dc_addr_q    <= '0;
      dc_wdata_q   <= '0;
      dc_wmask_q   <= '0;
      resp_rdata_q <= '0;
      resp_mis_q   <= 1'b0;
    end else begin
      if (accept) begin
        rw_q         <= lsu.req_rw;
        size_q       <= lsu.req_size;
        unsigned_q   <= lsu.req_unsigned;
        off_q        <= lsu.req_addr[1:0];
        rd_q         <= lsu.req_rd;
        dc_addr_q    <= {lsu.req_addr[ADDR_LENGTH-1:2], 2'b00};
        dc_wdata_q   <= dc_wdata_d;
        dc_wmask_q   <= dc_wmask_d;
        resp_rdata_q <= '0;
        resp_mis_q   <= misaligned;
      end
      if (capture) resp_rdata_q <= load_ext;
    end
  end

  assign lsu.req_ready       = (state_q == S_IDLE);
  assign lsu.resp_valid      = (state_q == S_RESP);
  assign lsu.resp_rdata      = resp_rdata_q;
  assign lsu.resp_rd         = rd_q;
  assign lsu.resp_misaligned = resp_mis_q;

  assign dc.dc_valid = (state_q == S_ISSUE);
  assign dc.dc_addr  = dc_addr_q;
  assign dc.dc_wdata = dc_wdata_q;
  assign dc.dc_wmask = dc_wmask_q;
  assign dc.dc_rw    = rw_q;

endmodule

// File: tb/tb_lsu_dcache_adapter.sv
// Directed bench for lsu_dcache_adapter: table of ops with hand-computed
// cache-side fields and results, plus a mid-operation reset.

module tb_lsu_dcache_adapter;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  lsu_req_if #(.DATA_LENGTH(32), .ADDR_LENGTH(32)) lsu ();
  dcache_if  #(.DATA_LENGTH(32), .ADDR_LENGTH(32)) dc ();

  lsu_dcache_adapter #(.DATA_LENGTH(32), .ADDR_LENGTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .lsu   (lsu),
    .dc    (dc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One op end to end; rv_dly = 0 returns rdata in the handshake cycle.
  task automatic run_op(
    input string       name,
    input logic        rw,
    input logic [1:0]  size,
    input logic        uns,
    input logic [31:0] addr,
    input logic [31:0] wdata,
    input logic [4:0]  rd,
    input int          rdy_dly,
    input int          rv_dly,
    input int          resp_hold,
    input logic [31:0] rdata,
    input logic        exp_mis,
    input logic [31:0] exp_addr,
    input logic [31:0] exp_mask,
    input logic [31:0] exp_wdata,
    input logic [31:0] exp_rdata
  );
    chk({name, ".req_ready_idle"}, 32'(lsu.req_ready), 32'd1);
    lsu.req_valid    = 1'b1;
    lsu.req_rw       = rw;
    lsu.req_size     = size;
    lsu.req_unsigned = uns;
    lsu.req_addr     = addr;
    lsu.req_wdata    = wdata;
    lsu.req_rd       = rd;
    tick();
    lsu.req_valid = 1'b0;
    lsu.req_addr  = 32'hFFFF_FFFF;
    lsu.req_wdata = 32'h5A5A_5A5A;
    if (exp_mis) begin
      chk({name, ".dc_valid_mis"}, 32'(dc.dc_valid), 32'd0);
    end else begin
      for (int i = 0; i < rdy_dly; i++) begin
        dc.dc_ready  = 1'b0;
        dc.dc_rvalid = 1'b1;
        dc.dc_rdata  = 32'h0BAD_0BAD;
        chk({name, ".dc_valid_hold"}, 32'(dc.dc_valid), 32'd1);
        chk({name, ".dc_addr_hold"},  dc.dc_addr,  exp_addr);
        chk({name, ".dc_wmask_hold"}, dc.dc_wmask, exp_mask);
        chk({name, ".dc_wdata_hold"}, dc.dc_wdata, exp_wdata);
        tick();
      end
      dc.dc_ready = 1'b1;
      chk({name, ".dc_valid"}, 32'(dc.dc_valid), 32'd1);
      chk({name, ".dc_addr"},  dc.dc_addr,  exp_addr);
      chk({name, ".dc_rw"},    32'(dc.dc_rw), 32'(rw));
      chk({name, ".dc_wmask"}, dc.dc_wmask, exp_mask);
      chk({name, ".dc_wdata"}, dc.dc_wdata, exp_wdata);
      dc.dc_rvalid = (!rw && rv_dly == 0);
      dc.dc_rdata  = (!rw && rv_dly == 0) ? rdata : 32'h0BAD_0BAD;
      tick();
      dc.dc_ready  = 1'b0;
      dc.dc_rvalid = 1'b0;
      if (!rw) begin
        for (int i = 0; i < rv_dly; i++) begin
          dc.dc_rvalid = (i == rv_dly - 1);
          dc.dc_rdata  = (i == rv_dly - 1) ? rdata : 32'h0BAD_0BAD;
          chk({name, ".wait_dc_valid"},   32'(dc.dc_valid),   32'd0);
          chk({name, ".wait_resp_valid"}, 32'(lsu.resp_valid), 32'd0);
          chk({name, ".wait_req_ready"},  32'(lsu.req_ready),  32'd0);
          tick();
        end
        dc.dc_rvalid = 1'b0;
      end
    end
    for (int i = 0; i <= resp_hold; i++) begin
      lsu.resp_ready = (i == resp_hold);
      dc.dc_rvalid   = 1'b1;
      dc.dc_rdata    = 32'h7777_7777;
      chk({name, ".resp_valid"},      32'(lsu.resp_valid),      32'd1);
      chk({name, ".resp_req_ready"},  32'(lsu.req_ready),       32'd0);
      chk({name, ".resp_dc_valid"},   32'(dc.dc_valid),         32'd0);
      chk({name, ".resp_rdata"},      lsu.resp_rdata,           exp_rdata);
      chk({name, ".resp_rd"},         32'(lsu.resp_rd),         32'(rd));
      chk({name, ".resp_misaligned"}, 32'(lsu.resp_misaligned), 32'(exp_mis));
      tick();
    end
    lsu.resp_ready = 1'b0;
    dc.dc_rvalid   = 1'b0;
    chk({name, ".resp_valid_drop"}, 32'(lsu.resp_valid), 32'd0);
    chk({name, ".req_ready_back"},  32'(lsu.req_ready),  32'd1);
  endtask

  initial begin
    checks           = 0;
    errors           = 0;
    rst_n            = 1'b0;
    lsu.req_valid    = 1'b0;
    lsu.req_rw       = 1'b0;
    lsu.req_size     = 2'b00;
    lsu.req_unsigned = 1'b0;
    lsu.req_addr     = '0;
    lsu.req_wdata    = '0;
    lsu.req_rd       = '0;
    lsu.resp_ready   = 1'b0;
    dc.dc_ready      = 1'b0;
    dc.dc_rdata      = '0;
    dc.dc_rvalid     = 1'b0;
    #12;
    chk("rst.req_ready",  32'(lsu.req_ready),  32'd1);
    chk("rst.dc_valid",   32'(dc.dc_valid),    32'd0);
    chk("rst.resp_valid", 32'(lsu.resp_valid), 32'd0);
    chk("rst.dc_addr",    dc.dc_addr,          32'd0);
    chk("rst.dc_wmask",   dc.dc_wmask,         32'd0);
    chk("rst.resp_rdata", lsu.resp_rdata,      32'd0);
    #1 rst_n = 1'b1;
    tick();

    //      name     rw    size   uns   addr          wdata         rd     rdy rv hold rdata         mis   dc_addr       wmask         wdata         result
    run_op("ldw",   1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0,        5'd5,  0,  0, 0, 32'hDEAD_BEEF, 1'b0, 32'h0000_0100, 32'h0,        32'h0,        32'hDEAD_BEEF);
    run_op("ldb_s", 1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0,        5'd7,  0,  0, 0, 32'h8011_2233, 1'b0, 32'h0000_0100, 32'h0,        32'h0,        32'hFFFF_FF80);
    run_op("ldb_u", 1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'h0,        5'd8,  0,  0, 0, 32'h8011_2233, 1'b0, 32'h0000_0100, 32'h0,        32'h0,        32'h0000_0080);
    run_op("sth",   1'b1, 2'b01, 1'b0, 32'h0000_0022, 32'h1234_ABCD, 5'd9,  3,  0, 0, 32'h0,        1'b0, 32'h0000_0020, 32'hFFFF_0000, 32'hABCD_0000, 32'h0);
    run_op("ldw_m", 1'b0, 2'b10, 1'b0, 32'h0000_0102, 32'h0,        5'd10, 0,  0, 0, 32'h0,        1'b1, 32'h0,        32'h0,        32'h0,        32'h0);
    run_op("sz11",  1'b0, 2'b11, 1'b0, 32'h0000_0100, 32'h0,        5'd11, 0,  0, 0, 32'h0,        1'b1, 32'h0,        32'h0,        32'h0,        32'h0);
    run_op("ldh_w", 1'b0, 2'b01, 1'b0, 32'h0000_0102, 32'h0,        5'd12, 0,  5, 2, 32'h8001_1234, 1'b0, 32'h0000_0100, 32'h0,        32'h0,        32'hFFFF_8001);
    run_op("stb",   1'b1, 2'b00, 1'b0, 32'h0000_0101, 32'hFFFF_FF55, 5'd13, 1,  0, 1, 32'h0,        1'b0, 32'h0000_0100, 32'h0000_FF00, 32'h0000_5500, 32'h0);
    run_op("stw",   1'b1, 2'b10, 1'b0, 32'h0000_0040, 32'hCAFE_F00D, 5'd14, 0,  0, 0, 32'h0,        1'b0, 32'h0000_0040, 32'hFFFF_FFFF, 32'hCAFE_F00D, 32'h0);
    run_op("ldh_u", 1'b0, 2'b01, 1'b1, 32'h0000_0100, 32'h0,        5'd15, 0,  1, 0, 32'h1234_F00F, 1'b0, 32'h0000_0100, 32'h0,        32'h0,        32'h0000_F00F);
    run_op("sth_m", 1'b1, 2'b01, 1'b0, 32'h0000_0021, 32'h0000_1111, 5'd16, 0,  0, 0, 32'h0,        1'b1, 32'h0,        32'h0,        32'h0,        32'h0);
    run_op("ldb_1", 1'b0, 2'b00, 1'b1, 32'h0000_0101, 32'h0,        5'd17, 2,  3, 0, 32'h1122_3344, 1'b0, 32'h0000_0100, 32'h0,        32'h0,        32'h0000_0033);

    // Reset while a load sits in WAIT; a late rvalid must not revive it.
    lsu.req_valid    = 1'b1;
    lsu.req_rw       = 1'b0;
    lsu.req_size     = 2'b10;
    lsu.req_unsigned = 1'b0;
    lsu.req_addr     = 32'h0000_0200;
    lsu.req_rd       = 5'd21;
    tick();
    lsu.req_valid = 1'b0;
    dc.dc_ready   = 1'b1;
    tick();
    dc.dc_ready = 1'b0;
    chk("rstw.in_wait", 32'(lsu.req_ready), 32'd0);
    chk("rstw.dc_addr_pre", dc.dc_addr, 32'h0000_0200);
    #2 rst_n = 1'b0;
    #1;
    chk("rstw.req_ready",  32'(lsu.req_ready),  32'd1);
    chk("rstw.dc_valid",   32'(dc.dc_valid),    32'd0);
    chk("rstw.resp_valid", 32'(lsu.resp_valid), 32'd0);
    chk("rstw.dc_addr",    dc.dc_addr,          32'd0);
    chk("rstw.resp_rd",    32'(lsu.resp_rd),    32'd0);
    #3 rst_n = 1'b1;
    tick();
    dc.dc_rvalid   = 1'b1;
    dc.dc_rdata    = 32'h1357_9BDF;
    lsu.resp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      dc.dc_rvalid = 1'b0;
      chk("rstw.no_resp",   32'(lsu.resp_valid), 32'd0);
      chk("rstw.idle",      32'(lsu.req_ready),  32'd1);
      chk("rstw.rdata_clr", lsu.resp_rdata,      32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
